// File: rtl/gearbox_pair_arbiter_pkg.sv
// Shared types and helpers for the pair-granular gearbox arbiter.
package gearbox_arb_pkg;

  typedef enum logic {IDLE, HALF} gb_arb_state_t;

  localparam int unsigned MaxCh = 32;

  // First set bit of req scanning ptr+1, ptr+2, ... modulo n; 0 if none set.
  function automatic int unsigned rr_pick(input logic [MaxCh-1:0] req,
                                          input int unsigned      ptr,
                                          input int unsigned      n);
    int unsigned idx;
    bit          found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (!found && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/gearbox_pair_arbiter_if.sv
// Upstream narrow beats, downstream wide pairs and timeout-drop reporting.
interface gearbox_pair_arbiter_if #(
  parameter int unsigned width = 8,
  parameter int unsigned n_ch  = 4
);
  localparam int unsigned id_w = $clog2(n_ch);

  logic [n_ch-1:0]       up_vld;
  logic [n_ch*width-1:0] up_data;
  logic [n_ch-1:0]       up_rdy;
  logic                  down_vld;
  logic [2*width-1:0]    down_data;
  logic [id_w-1:0]       down_id;
  logic                  drop_vld;
  logic [id_w-1:0]       drop_id;

  modport master (
    output up_vld, up_data,
    input  up_rdy, down_vld, down_data, down_id, drop_vld, drop_id
  );

  modport slave (
    input  up_vld, up_data,
    output up_rdy, down_vld, down_data, down_id, drop_vld, drop_id
  );

endinterface

// File: rtl/gearbox_pair_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus its index.
module rr_arbiter
  import gearbox_arb_pkg::*;
#(
  parameter  int unsigned n_ch = 4,
  localparam int unsigned id_w = $clog2(n_ch)
) (
  input  logic [n_ch-1:0] i_req,
  input  logic [id_w-1:0] i_ptr,
  output logic [n_ch-1:0] o_grant,
  output logic [id_w-1:0] o_grant_idx
);

  always_comb begin
    o_grant_idx = id_w'(rr_pick(MaxCh'(i_req), 32'(i_ptr), n_ch));
    o_grant     = (|i_req) ? (n_ch'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/gearbox_pair_arbiter.sv
// Shares a 1-to-2 width-doubling path; grants are held for a whole pair of beats,
// and a half-word abandoned for too long is dropped and reported.
module gearbox_pair_arbiter
  import gearbox_arb_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned n_ch    = 4,
  parameter int unsigned timeout = 16
) (
  input logic                  clk,
  input logic                  rst,
  gearbox_pair_arbiter_if.slave bus
);

  localparam int unsigned id_w = $clog2(n_ch);

  gb_arb_state_t    r_state, w_state_d;
  logic [width-1:0] r_first_part, w_first_part_d;
  logic [id_w-1:0]  r_lock_id, w_lock_id_d;
  logic [id_w-1:0]  r_rr_ptr, w_rr_ptr_d;
  logic [31:0]      r_idle_cnt, w_idle_cnt_d;

  logic [width-1:0] w_beat [n_ch];
  logic [n_ch-1:0]  w_grant;
  logic [id_w-1:0]  w_grant_idx;

  logic [n_ch-1:0]    w_up_rdy;
  logic               w_down_vld;
  logic [2*width-1:0] w_down_data;
  logic [id_w-1:0]    w_down_id;
  logic               w_drop_vld;
  logic [id_w-1:0]    w_drop_id;

  for (genvar i = 0; i < n_ch; i++) begin : g_unpack
    assign w_beat[i] = bus.up_data[i*width +: width];
  end

  rr_arbiter #(
    .n_ch(n_ch)
  ) u_rr_arbiter (
    .i_req      (bus.up_vld),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx)
  );

  always_comb begin
    w_state_d      = r_state;
    w_first_part_d = r_first_part;
    w_lock_id_d    = r_lock_id;
    w_rr_ptr_d     = r_rr_ptr;
    w_idle_cnt_d   = r_idle_cnt;
    w_up_rdy       = '0;
    w_down_vld     = 1'b0;
    w_down_data    = '0;
    w_down_id      = '0;
    w_drop_vld     = 1'b0;
    w_drop_id      = '0;

    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          w_up_rdy = w_grant;
          if (|bus.up_vld) begin
            w_first_part_d = w_beat[w_grant_idx];
            w_lock_id_d    = w_grant_idx;
            w_idle_cnt_d   = '0;
            w_state_d      = HALF;
          end
        end
        HALF: begin
          w_up_rdy = n_ch'(1) << r_lock_id;
          if (bus.up_vld[r_lock_id]) begin
            // Second beat completes the pair in the same cycle it is accepted.
            w_down_vld  = 1'b1;
            w_down_data = {r_first_part, w_beat[r_lock_id]};
            w_down_id   = r_lock_id;
            w_rr_ptr_d  = r_lock_id;
            w_state_d   = IDLE;
          end else if (timeout != 0 && r_idle_cnt == timeout - 1) begin
            w_up_rdy     = '0;
            w_drop_vld   = 1'b1;
            w_drop_id    = r_lock_id;
            w_rr_ptr_d   = r_lock_id;
            w_idle_cnt_d = '0;
            w_state_d    = IDLE;
          end else begin
            w_idle_cnt_d = r_idle_cnt + 32'd1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_first_part <= '0;
      r_lock_id    <= '0;
      r_rr_ptr     <= id_w'(n_ch - 1);
      r_idle_cnt   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_first_part <= w_first_part_d;
      r_lock_id    <= w_lock_id_d;
      r_rr_ptr     <= w_rr_ptr_d;
      r_idle_cnt   <= w_idle_cnt_d;
    end
  end

  assign bus.up_rdy    = w_up_rdy;
  assign bus.down_vld  = w_down_vld;
  assign bus.down_data = w_down_data;
  assign bus.down_id   = w_down_id;
  assign bus.drop_vld  = w_drop_vld;
  assign bus.drop_id   = w_drop_id;

endmodule

// File: doc/gearbox_pair_arbiter.md
Name: gearbox_pair_arbiter

Overview:
- Shares one 1-to-2 width-doubling path between n_ch upstream requesters.
- Round-robin arbitration is per pair, not per beat. Once a requester's first beat is accepted, the grant is locked to it until its second beat completes the 2*width word.
- The completed word leaves on down_data with the source id.
- Sits between per-channel narrow producers and a single wide downstream consumer. The consumer has no backpressure.

Parameters:
- width, 8: upstream beat width in bits; must be >= 1.
- n_ch, 4: number of requesters; must be >= 2.
- timeout, 16: number of idle cycles allowed in HALF before the held half-word is dropped; 0 disables the timeout.
- id_w, $clog2(n_ch): width of the id fields; derived, not overridden.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- up_vld  in  n_ch  per-requester beat valid.
- up_data  in  n_ch*width  packed beats; requester i occupies [i*width +: width].
- up_rdy  out  n_ch  per-requester accept; a beat transfers when up_vld[i] & up_rdy[i].
- down_vld  out  1  completed pair valid; single-cycle pulse.
- down_data  out  2*width  {first beat, second beat}; zero when down_vld=0.
- down_id  out  id_w  requester that produced down_data; zero when down_vld=0.
- drop_vld  out  1  pulse: the held half-word was discarded by timeout.
- drop_id  out  id_w  requester whose half-word was dropped; zero when drop_vld=0.

Behaviour:
- State machine has two states: IDLE (no half-word held) and HALF (first_part held for lock_id).
- Registers: state, first_part[width], lock_id, rr_ptr (last requester served), idle_cnt.

Reset (rst=1 at an edge):
- state=IDLE, first_part=0, lock_id=0, rr_ptr=n_ch-1 (so requester 0 has top priority first), idle_cnt=0.
- While rst=1, all outputs are 0: up_rdy=0, down_vld=0, drop_vld=0.
- A mid-pair reset discards the held half-word silently; no drop pulse is generated.

IDLE:
- grant g = first i with up_vld[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo n_ch.
- up_rdy is one-hot at g (combinational). If no up_vld is set, up_rdy=0.
- On transfer: first_part<=up_data[g], lock_id<=g, idle_cnt<=0, state<=HALF.
- down_vld=0 in IDLE.

HALF:
- up_rdy is one-hot at lock_id regardless of the other up_vld bits. Other requesters stall, no starvation within a pair.
- If up_vld[lock_id]=1, in the same cycle (zero-cycle latency from the second beat):
  - down_vld=1, down_data={first_part, up_data[lock_id]}, down_id=lock_id;
  - next edge: rr_ptr<=lock_id, state<=IDLE.
- IDLE is entered at that edge. A new grant can occur the next cycle, so the sustained throughput is one pair per 2 cycles. This matches the 1-to-2 rate, since one beat is accepted per cycle.
- If up_vld[lock_id]=0, idle_cnt increments.
- If timeout!=0 and idle_cnt==timeout-1 in a cycle with no beat:
  - that cycle: drop_vld=1, drop_id=lock_id;
  - next edge: state<=IDLE, rr_ptr<=lock_id, up_rdy=0 at that cycle.

Boundary conditions:
- A beat and the timeout in the same cycle: the beat wins and no drop occurs.
- All requesters valid every cycle: pairs are served 0,1,2,3,0,... with each pair being two consecutive beats.
- A single active requester is served back-to-back with no bubble beyond the IDLE cycle. IDLE accepts in the cycle it is entered.
- rr_ptr wraps from n_ch-1 to 0.
- down_vld and drop_vld are never asserted together.

Decomposition:
- Package gearbox_arb_pkg: typedef enum logic {IDLE, HALF} gb_arb_state_t, plus a function rr_pick(req, ptr) returning the index.
- One sub-module: rr_arbiter (n_ch parameter; inputs req and ptr; outputs one-hot grant and grant index; combinational). Instantiated once in IDLE.

Test Plan (n_ch=4, width=8, timeout=4):
- Single requester: up_vld[2]=1 with beats 0xA1, 0xB2 on consecutive cycles -> down_vld pulse in the 0xB2 cycle, down_data=0xA1B2, down_id=2; up_rdy only ever 0b0100.
- All four valid continuously with beats tagged 0xi0, 0xi1 -> pairs emitted in order 0,1,2,3,0, e.g. 0x0001 id0 then 0x1011 id1; one down_vld every other cycle.
- Lock holding: requester 1 sends its first beat, then drops vld for 2 cycles while requester 3 is valid -> up_rdy stays 0b0010; requester 1's second beat 0x55 completes its pair; requester 3 is granted the next cycle.
- Timeout: requester 0 sends 0x7E then goes silent -> drop_vld=1, drop_id=0 on the 4th idle cycle; no down_vld; next grant goes to requester 1 if it is valid.
- Beat and timeout together: second beat arrives on the 4th idle cycle -> down_vld=1, drop_vld=0.
- Reset mid-pair: rst for 1 cycle after the first beat 0x33 of requester 2 -> all outputs 0; afterwards requester 0 wins a tie with requester 2; no stale 0x33 ever appears in down_data.
